// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store initiator for a word-addressed data memory.
// Sub-word stores are done as a read-modify-write over two cycles.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        ERR
    } state_t;

    state_t state, state_nx;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;

    logic              accept;
    logic              bad_f3;
    logic              misalign;
    logic              out_of_range;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       merged;
    logic [31:0]       ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign accept = req_valid && (state == IDLE);

    // Request checks are made on the live inputs so ERR is chosen at accept
    always_comb begin
        word_idx = ADDR_W'(req_addr[ADDR_W-1:2]);
        out_of_range = word_idx >= ADDR_W'(MEM_WORDS);
        if (req_we) begin
            bad_f3 = req_funct3 > 3'b010;
        end else begin
            bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misalign = 1'b0;
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            misalign = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            misalign = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_f3 || misalign || out_of_range) begin
                        state_nx = ERR;
                    end else if (!req_we) begin
                        state_nx = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_nx = STORE;
                    end else begin
                        state_nx = RMW_RD;
                    end
                end
            end
            RMW_RD:  state_nx = RMW_WR;
            LOAD, STORE, RMW_WR, ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        if (f3_q[0]) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RMW_RD) begin
                merge_q <= merged;
            end
        end
    end

    always_comb begin
        ld_byte = mem_rd[8*addr_q[1:0] +: 8];
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rd;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        mem_a      = {addr_q[ADDR_W-1:2], 2'b00};
        unique case (state)
            IDLE: req_ready = 1'b1;
            LOAD: begin
                resp_valid = 1'b1;
                resp_rdata = we_q ? 32'h0 : ld_data;
            end
            STORE: begin
                resp_valid = 1'b1;
                mem_we     = 1'b1;
                mem_wd     = wdata_q;
            end
            RMW_RD: begin
            end
            RMW_WR: begin
                resp_valid = 1'b1;
                mem_we     = 1'b1;
                mem_wd     = merge_q;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory.
// Vector table plus hand-written reset-abort and back-to-back sequences.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];

    int checks;
    int errors;
    int resp_cnt;
    int we_cnt;

    lsu_mem_ctrl #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    end

    always @(negedge clk) begin
        if (resp_valid) resp_cnt = resp_cnt + 1;
        if (mem_we) we_cnt = we_cnt + 1;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        rmw;
        logic [31:0] rdata;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic err, logic rmw,
                                logic [31:0] rdata, logic [31:0] wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rmw = rmw; v.rdata = rdata; v.wd = wd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v, int idx);
        logic exp_we;
        exp_we = v.we && !v.err;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d_quiet", idx), 32'(resp_valid), 32'd0);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_we && v.rmw) begin
            chk($sformatf("v%0d_rmwrd_resp", idx), 32'(resp_valid), 32'd0);
            chk($sformatf("v%0d_rmwrd_we", idx), 32'(mem_we), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("v%0d_resp", idx), 32'(resp_valid), 32'd1);
        chk($sformatf("v%0d_err", idx), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(exp_we));
        chk($sformatf("v%0d_wd", idx), mem_wd, exp_we ? v.wd : 32'h0);
        chk($sformatf("v%0d_a", idx), mem_a, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_busy", idx), 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic exp_ready;
        checks     = 0;
        errors     = 0;
        resp_cnt   = 0;
        we_cnt     = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        //      we  f3     addr      wdata        err  rmw rdata         wd
        vecs.push_back(mk(1, 3'b010, 32'h40,  32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h40,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h40,  32'h80FF7F01, 0, 0, 32'h0,        32'h80FF7F01));
        vecs.push_back(mk(0, 3'b000, 32'h43,  32'h0,        0, 0, 32'hFFFFFF80, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h43,  32'h0,        0, 0, 32'h00000080, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h42,  32'h0,        0, 0, 32'hFFFF80FF, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h40,  32'h0,        0, 0, 32'h00007F01, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h41,  32'h0,        0, 0, 32'h0000007F, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h40,  32'h11223344, 0, 0, 32'h0,        32'h11223344));
        vecs.push_back(mk(1, 3'b000, 32'h41,  32'h000000AB, 0, 1, 32'h0,        32'h1122AB44));
        vecs.push_back(mk(1, 3'b001, 32'h42,  32'h0000CAFE, 0, 1, 32'h0,        32'hCAFEAB44));
        vecs.push_back(mk(0, 3'b010, 32'h40,  32'h0,        0, 0, 32'hCAFEAB44, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h42,  32'h0,        1, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h41,  32'h00001234, 1, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h1000, 32'h55555555, 1, 0, 32'h0,       32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h40,  32'h0,        1, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h40,  32'h77777777, 1, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h43,  32'h0,        1, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h40,  32'h0,        0, 0, 32'hCAFEAB44, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h41,  32'h0,        0, 0, 32'hFFFFFFAB, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h40,  32'h0,        0, 0, 32'h00000044, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'hFFC, 32'h12345678, 0, 0, 32'h0,        32'h12345678));
        vecs.push_back(mk(0, 3'b101, 32'hFFE, 32'h0,        0, 0, 32'h00001234, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h44,  32'h99887766, 0, 0, 32'h0,        32'h99887766));

        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", mem_a, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Abort a sub-word store while it is reading the old word
        @(negedge clk);
        resp_cnt   = 0;
        we_cnt     = 0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h44;
        req_wdata  = 32'h000000EE;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_rmwrd", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_we_async", 32'(mem_we), 32'd0);
        chk("abort_ready_async", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_we_cnt", 32'(we_cnt), 32'd0);
        chk("abort_resp_cnt", 32'(resp_cnt), 32'd0);
        chk("abort_mem", mem[17], 32'h99887766);
        chk("abort_ready", 32'(req_ready), 32'd1);

        // Hold req_valid high with alternating LW/SW
        resp_cnt  = 0;
        exp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_valid  = 1'b1;
            req_we     = c[0];
            req_funct3 = 3'b010;
            req_addr   = 32'h80;
            req_wdata  = 32'(c);
            #1;
            chk($sformatf("b2b%0d_ready", c), 32'(req_ready), 32'(exp_ready));
            chk($sformatf("b2b%0d_resp", c), 32'(resp_valid), 32'(!exp_ready));
            exp_ready = !exp_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_resp_cnt", 32'(resp_cnt), 32'd3);
        chk("b2b_idle", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
